mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO port between instruction fetch (IF) and the

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_byte_seq.sv | 70 +++++++
 rtl/mem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the memory arbiter.
//   - address / word geometry and IO decode base
//   - LSB access size encodings and size -> byte-count decode
//   - FSM state and grant-owner encodings
package mem_arbiter_pkg;

  localparam int unsigned AddressWidth = 32;
  localparam int unsigned WordBytes    = 4;
  localparam logic [31:0] IoBase       = 32'h0003_0000;

  localparam logic [1:0] SizeB = 2'b00;
  localparam logic [1:0] SizeH = 2'b01;
  localparam logic [1:0] SizeW = 2'b10;

  typedef enum logic [1:0] {StIdle, StIfRd, StLsRd, StLsWr} state_e;
  typedef enum logic {GrantIf = 1'b0, GrantLsb = 1'b1} grant_e;

  // Reserved encoding 2'b11 is treated as a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SizeB:   return 3'd1;
      SizeH:   return 3'd2;
      SizeW:   return 3'(WordBytes);
      default: return 3'(WordBytes);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer for the arbiter: issue/capture byte counters, byte address
// generation and little-endian split/assemble of the data word.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_en                 advance enable (global ready)
//   i_clr                clear both counters
//   i_tx_inc, i_rx_inc   bump issue / capture counter (saturate at WORD_BYTES)
//   i_base, i_wdata      latched base address and store word
//   i_rdata, i_din       partially assembled load word and incoming RAM byte
//   o_tx_idx, o_rx_idx   current issue / capture byte index
//   o_addr               base + issue index (wraps)
//   o_wbyte              store byte selected by the issue index
//   o_word               i_rdata with byte o_rx_idx replaced by i_din
module mem_arbiter_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddressWidth,
  parameter int unsigned WORD_BYTES = WordBytes
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic                    i_tx_inc,
  input  logic                    i_rx_inc,
  input  logic [ADDR_WIDTH-1:0]   i_base,
  input  logic [8*WORD_BYTES-1:0] i_wdata,
  input  logic [8*WORD_BYTES-1:0] i_rdata,
  input  logic [7:0]              i_din,
  output logic [2:0]              o_tx_idx,
  output logic [2:0]              o_rx_idx,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [7:0]              o_wbyte,
  output logic [8*WORD_BYTES-1:0] o_word
);

  localparam logic [2:0] MaxCnt = 3'(WORD_BYTES);

  logic [2:0] r_tx;
  logic [2:0] r_rx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx <= '0;
      r_rx <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_tx <= '0;
        r_rx <= '0;
      end else begin
        if (i_tx_inc && (r_tx < MaxCnt)) r_tx <= r_tx + 3'd1;
        if (i_rx_inc && (r_rx < MaxCnt)) r_rx <= r_rx + 3'd1;
      end
    end
  end

  assign o_tx_idx = r_tx;
  assign o_rx_idx = r_rx;
  assign o_addr   = i_base + {{(ADDR_WIDTH-3){1'b0}}, r_tx};

  always_comb begin
    o_wbyte = '0;
    o_word  = i_rdata;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (r_tx == 3'(b)) o_wbyte = i_wdata[8*b +: 8];
      if (r_rx == 3'(b)) o_word[8*b +: 8] = i_din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM/IO port between instruction fetch (IF)
// and the load/store buffer (LSB). Multi-byte accesses go one byte per cycle,
// loads are assembled little-endian and zero-extended, and each requester gets
// a one-cycle done pulse. The RAM read port is assumed to pause with rdy_in.
// Ports:
//   clk_in, rst_in, rdy_in                  clock, async active-low reset, global ready
//   mem_din_in/mem_dout_out/mem_a_out/mem_wr_out  RAM byte port
//   io_buffer_full_in                       stalls IO writes while high
//   if_mem_req_in/addr_in, mem_if_done_out/data_out           IF word fetch
//   lsb_mem_req/wr/size/addr/data_in, mem_lsb_done/data_out   LSB load/store
//   rob_mem_rst_in                          flush: aborts reads, stores complete
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddressWidth,
  parameter int unsigned WORD_BYTES = WordBytes,
  parameter logic [31:0] IO_BASE    = IoBase
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din_in,
  output logic [7:0]              mem_dout_out,
  output logic [ADDR_WIDTH-1:0]   mem_a_out,
  output logic                    mem_wr_out,
  input  logic                    io_buffer_full_in,
  input  logic                    if_mem_req_in,
  input  logic [ADDR_WIDTH-1:0]   if_mem_addr_in,
  output logic                    mem_if_done_out,
  output logic [8*WORD_BYTES-1:0] mem_if_data_out,
  input  logic                    lsb_mem_req_in,
  input  logic                    lsb_mem_wr_in,
  input  logic [1:0]              lsb_mem_size_in,
  input  logic [ADDR_WIDTH-1:0]   lsb_mem_addr_in,
  input  logic [8*WORD_BYTES-1:0] lsb_mem_data_in,
  output logic                    mem_lsb_done_out,
  output logic [8*WORD_BYTES-1:0] mem_lsb_data_out,
  input  logic                    rob_mem_rst_in
);

  state_e                  r_state;
  grant_e                  r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_base, r_mem_a;
  logic [8*WORD_BYTES-1:0] r_wdata, r_rdata, r_if_data, r_lsb_data;
  logic [2:0]              r_nbytes;
  logic                    r_is_io, r_a_vld, r_s_vld;
  logic [7:0]              r_mem_dout;
  logic                    r_mem_wr, r_if_done, r_lsb_done;

  logic [2:0]              w_tx_idx, w_rx_idx;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [7:0]              w_wbyte;
  logic [8*WORD_BYTES-1:0] w_word;
  logic                    w_clr, w_tx_inc, w_rx_inc;

  // A requester whose done is showing still has its stale request up.
  logic w_if_elig, w_lsb_elig, w_pick_lsb, w_grant;
  assign w_if_elig  = if_mem_req_in && !r_if_done;
  assign w_lsb_elig = lsb_mem_req_in && !r_lsb_done;
  assign w_pick_lsb = w_lsb_elig && (!w_if_elig || (r_last_grant == GrantIf));
  assign w_grant    = (r_state == StIdle) && !rob_mem_rst_in && (w_if_elig || w_lsb_elig);

  logic w_new_io, w_new_stall, w_io_stall, w_tx_left, w_last_rx;
  assign w_new_io    = (lsb_mem_addr_in[17:16] == IO_BASE[17:16]);
  assign w_new_stall = w_pick_lsb && lsb_mem_wr_in && w_new_io && io_buffer_full_in;
  assign w_io_stall  = r_is_io && io_buffer_full_in;
  assign w_tx_left   = (w_tx_idx < r_nbytes);
  // Address issued at Ei is sampled by the RAM at E(i+1); its byte is taken at E(i+2).
  assign w_last_rx   = r_s_vld && (w_rx_idx == (r_nbytes - 3'd1));

  always_comb begin
    w_clr    = 1'b0;
    w_tx_inc = 1'b0;
    w_rx_inc = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant) w_tx_inc = !w_new_stall;
        else         w_clr    = 1'b1;
      end
      StIfRd, StLsRd: begin
        if (rob_mem_rst_in || w_last_rx) begin
          w_clr = 1'b1;
        end else begin
          w_tx_inc = w_tx_left;
          w_rx_inc = r_s_vld;
        end
      end
      StLsWr: begin
        if (!w_tx_left) w_clr    = 1'b1;
        else            w_tx_inc = !w_io_stall;
      end
      default: w_clr = 1'b1;
    endcase
  end

  mem_arbiter_byte_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_BYTES (WORD_BYTES)
  ) u_byte_seq (
    .i_clk    (clk_in),
    .i_rst_n  (rst_in),
    .i_en     (rdy_in),
    .i_clr    (w_clr),
    .i_tx_inc (w_tx_inc),
    .i_rx_inc (w_rx_inc),
    .i_base   (r_base),
    .i_wdata  (r_wdata),
    .i_rdata  (r_rdata),
    .i_din    (mem_din_in),
    .o_tx_idx (w_tx_idx),
    .o_rx_idx (w_rx_idx),
    .o_addr   (w_addr),
    .o_wbyte  (w_wbyte),
    .o_word   (w_word)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= StIdle;
      r_last_grant <= GrantIf;
      r_base       <= '0;
      r_mem_a      <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_if_data    <= '0;
      r_lsb_data   <= '0;
      r_nbytes     <= '0;
      r_is_io      <= 1'b0;
      r_a_vld      <= 1'b0;
      r_s_vld      <= 1'b0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_if_done    <= 1'b0;
      r_lsb_done   <= 1'b0;
    end else if (rdy_in) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_rdata <= '0;
            r_s_vld <= 1'b0;
            if (w_pick_lsb) begin
              r_last_grant <= GrantLsb;
              r_base       <= lsb_mem_addr_in;
              r_mem_a      <= lsb_mem_addr_in;
              r_nbytes     <= size_to_bytes(lsb_mem_size_in);
              r_wdata      <= lsb_mem_data_in;
              r_is_io      <= w_new_io;
              if (lsb_mem_wr_in) begin
                r_state    <= StLsWr;
                r_mem_dout <= lsb_mem_data_in[7:0];
                r_mem_wr   <= !w_new_stall;
                r_a_vld    <= 1'b0;
              end else begin
                r_state <= StLsRd;
                r_a_vld <= 1'b1;
              end
            end else begin
              r_last_grant <= GrantIf;
              r_base       <= if_mem_addr_in;
              r_mem_a      <= if_mem_addr_in;
              r_nbytes     <= 3'(WORD_BYTES);
              r_is_io      <= 1'b0;
              r_state      <= StIfRd;
              r_a_vld      <= 1'b1;
            end
          end
        end
        StIfRd, StLsRd: begin
          if (rob_mem_rst_in) begin
            // Aborted read: also swallows a done that would land on this edge.
            r_state <= StIdle;
            r_a_vld <= 1'b0;
            r_s_vld <= 1'b0;
          end else begin
            r_s_vld <= r_a_vld;
            if (r_s_vld) r_rdata <= w_word;
            if (w_last_rx) begin
              r_state <= StIdle;
              r_a_vld <= 1'b0;
              r_s_vld <= 1'b0;
              if (r_state == StIfRd) begin
                r_if_done <= 1'b1;
                r_if_data <= w_word;
              end else begin
                r_lsb_done <= 1'b1;
                r_lsb_data <= w_word;
              end
            end else if (w_tx_left) begin
              r_mem_a <= w_addr;
              r_a_vld <= 1'b1;
            end else begin
              r_a_vld <= 1'b0;
            end
          end
        end
        StLsWr: begin
          // Committed stores ignore the flush.
          if (!w_tx_left) begin
            r_mem_wr   <= 1'b0;
            r_lsb_done <= 1'b1;
            r_state    <= StIdle;
          end else if (w_io_stall) begin
            r_mem_wr <= 1'b0;
          end else begin
            r_mem_a    <= w_addr;
            r_mem_dout <= w_wbyte;
            r_mem_wr   <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_a_out        = r_mem_a;
  assign mem_dout_out     = r_mem_dout;
  assign mem_wr_out       = r_mem_wr && rdy_in;
  assign mem_if_done_out  = r_if_done;
  assign mem_if_data_out  = r_if_data;
  assign mem_lsb_done_out = r_lsb_done;
  assign mem_lsb_data_out = r_lsb_data;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [31:0] a;
  logic        wr;
  logic        io_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = 2'b00;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_data;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .rdy_in            (rdy),
    .mem_din_in        (din),
    .mem_dout_out      (dout),
    .mem_a_out         (a),
    .mem_wr_out        (wr),
    .io_buffer_full_in (io_full),
    .if_mem_req_in     (if_req),
    .if_mem_addr_in    (if_addr),
    .mem_if_done_out   (if_done),
    .mem_if_data_out   (if_data),
    .lsb_mem_req_in    (lsb_req),
    .lsb_mem_wr_in     (lsb_wr),
    .lsb_mem_size_in   (lsb_size),
    .lsb_mem_addr_in   (lsb_addr),
    .lsb_mem_data_in   (lsb_wdata),
    .mem_lsb_done_out  (lsb_done),
    .mem_lsb_data_out  (lsb_data),
    .rob_mem_rst_in    (flush)
  );

  // Synchronous RAM that pauses together with the core; logs every byte written.
  logic [7:0]  mem [0:262143];
  logic [31:0] log_a [0:63];
  logic [7:0]  log_d [0:63];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (rdy) begin
      din <= mem[a[17:0]];
      if (wr) begin
        mem[a[17:0]]       <= dout;
        log_a[wr_cnt[5:0]] <= a;
        log_d[wr_cnt[5:0]] <= dout;
        wr_cnt             <= wr_cnt + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k = index of the edge (0 = first edge after the call) whose done was seen, -1 on timeout.
  task automatic wait_done(input bit on_lsb, input int budget, output int k,
                           output logic [31:0] data, output bit other);
    k = -1;
    data = '0;
    other = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (on_lsb ? if_done : lsb_done) other = 1'b1;
      if (on_lsb ? lsb_done : if_done) begin
        k = i;
        data = on_lsb ? lsb_data : if_data;
        break;
      end
    end
  endtask

  task automatic lsb_set(input logic w, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] dt);
    lsb_wr = w;
    lsb_size = sz;
    lsb_addr = ad;
    lsb_wdata = dt;
    lsb_req = 1'b1;
  endtask

  initial begin
    int          k;
    int          base;
    int          hi_cnt;
    int          first_hi;
    logic [31:0] d;
    bit          other;

    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    mem[18'h01000] = 8'h13; mem[18'h01001] = 8'h05;
    mem[18'h01002] = 8'h00; mem[18'h01003] = 8'h00;
    mem[18'h00040] = 8'h78; mem[18'h00041] = 8'h56;
    mem[18'h00042] = 8'h34; mem[18'h00043] = 8'h12;
    mem[18'h00022] = 8'hEE;

    // Reset state
    repeat (3) tick();
    check_eq("rst_mem_a", a, 32'h0);
    check_eq("rst_mem_wr", 32'(wr), 32'h0);
    check_eq("rst_mem_dout", 32'(dout), 32'h0);
    check_eq("rst_if_done", 32'(if_done), 32'h0);
    check_eq("rst_lsb_done", 32'(lsb_done), 32'h0);
    check_eq("rst_if_data", if_data, 32'h0);
    check_eq("rst_lsb_data", lsb_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Lone IF fetch; request held through the done cycle must not be re-granted
    if_addr = 32'h1000;
    if_req = 1'b1;
    wait_done(1'b0, 20, k, d, other);
    check_eq("if_latency", 32'(k), 32'd5);
    check_eq("if_data", d, 32'h0000_0513);
    tick();
    if_req = 1'b0;
    wait_done(1'b0, 10, k, d, other);
    check_eq("if_stale_regrant", 32'(k), 32'hFFFF_FFFF);

    // Tie with last grant = IF: LSB word load first, IF right after
    if_req = 1'b1;
    lsb_set(1'b0, 2'b10, 32'h40, 32'h0);
    wait_done(1'b1, 20, k, d, other);
    check_eq("tie1_lsb_latency", 32'(k), 32'd5);
    check_eq("tie1_lsb_data", d, 32'h1234_5678);
    check_eq("tie1_if_not_first", 32'(other), 32'h0);
    lsb_req = 1'b0;
    wait_done(1'b0, 20, k, d, other);
    check_eq("tie1_if_latency", 32'(k), 32'd5);
    check_eq("tie1_if_data", d, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // Lone byte load (zero-extended), then a tie with last grant = LSB: IF wins
    lsb_set(1'b0, 2'b00, 32'h41, 32'h0);
    wait_done(1'b1, 20, k, d, other);
    check_eq("lb_latency", 32'(k), 32'd2);
    check_eq("lb_data", d, 32'h0000_0056);
    lsb_req = 1'b0;
    tick();
    if_req = 1'b1;
    lsb_set(1'b0, 2'b01, 32'h42, 32'h0);
    wait_done(1'b0, 20, k, d, other);
    check_eq("tie2_if_latency", 32'(k), 32'd5);
    check_eq("tie2_lsb_not_first", 32'(other), 32'h0);
    if_req = 1'b0;
    wait_done(1'b1, 20, k, d, other);
    check_eq("tie2_lh_latency", 32'(k), 32'd3);
    check_eq("tie2_lh_data", d, 32'h0000_1234);
    lsb_req = 1'b0;
    tick();

    // Halfword store: two bytes, done at E2, neighbour untouched
    base = wr_cnt;
    lsb_set(1'b1, 2'b01, 32'h20, 32'hABCD_1234);
    wait_done(1'b1, 20, k, d, other);
    lsb_req = 1'b0;
    check_eq("sh_latency", 32'(k), 32'd2);
    check_eq("sh_wr_after_done", 32'(wr), 32'h0);
    tick();
    check_eq("sh_write_count", 32'(wr_cnt - base), 32'd2);
    check_eq("sh_b0_addr", log_a[base[5:0]], 32'h20);
    check_eq("sh_b0_data", 32'(log_d[base[5:0]]), 32'h34);
    check_eq("sh_b1_addr", log_a[6'(base + 1)], 32'h21);
    check_eq("sh_b1_data", 32'(log_d[6'(base + 1)]), 32'h12);
    check_eq("sh_neighbour", 32'(mem[18'h00022]), 32'hEE);

    // IO byte store held off by a full buffer for three edges
    base = wr_cnt;
    hi_cnt = 0;
    first_hi = -1;
    k = -1;
    io_full = 1'b1;
    lsb_set(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) io_full = 1'b0;
      if (wr) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
      if (lsb_done) begin
        k = i;
        break;
      end
    end
    lsb_req = 1'b0;
    check_eq("io_first_write_edge", 32'(first_hi), 32'd3);
    check_eq("io_write_cycles", 32'(hi_cnt), 32'd1);
    check_eq("io_done_edge", 32'(k), 32'd4);
    tick();
    check_eq("io_write_count", 32'(wr_cnt - base), 32'd1);
    check_eq("io_write_addr", log_a[base[5:0]], 32'h0003_0000);
    check_eq("io_write_data", 32'(log_d[base[5:0]]), 32'h41);

    // Flush at E2 of an IF read: no IF done, arbiter idle on the next edge
    if_addr = 32'h1000;
    if_req = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if_req = 1'b0;
    lsb_set(1'b0, 2'b10, 32'h40, 32'h0);
    wait_done(1'b1, 20, k, d, other);
    lsb_req = 1'b0;
    check_eq("flush_if_no_done", 32'(other), 32'h0);
    check_eq("flush_next_latency", 32'(k), 32'd5);
    check_eq("flush_next_data", d, 32'h1234_5678);
    tick();

    // Flush at E1 of a word store: store still completes
    base = wr_cnt;
    lsb_set(1'b1, 2'b10, 32'h50, 32'hDEAD_BEEF);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(1'b1, 10, k, d, other);
    lsb_req = 1'b0;
    check_eq("flush_sw_done_edge", 32'(k + 2), 32'd4);
    tick();
    check_eq("flush_sw_count", 32'(wr_cnt - base), 32'd4);
    check_eq("flush_sw_b0", 32'(mem[18'h00050]), 32'hEF);
    check_eq("flush_sw_b3", 32'(mem[18'h00053]), 32'hDE);

    // rdy low for 4 edges mid-read: same data, done 4 cycles later
    if_addr = 32'h1000;
    if_req = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    repeat (4) tick();
    check_eq("rdy_addr_held", a, 32'h1001);
    rdy = 1'b1;
    wait_done(1'b0, 20, k, d, other);
    if_req = 1'b0;
    check_eq("rdy_if_latency", 32'(6 + k), 32'd9);
    check_eq("rdy_if_data", d, 32'h0000_0513);
    tick();

    // rdy low during a byte store: write strobe forced low, store resumes
    base = wr_cnt;
    lsb_set(1'b1, 2'b00, 32'h60, 32'h0000_0077);
    tick();
    rdy = 1'b0;
    tick();
    check_eq("rdy_wr_forced_low", 32'(wr), 32'h0);
    tick();
    rdy = 1'b1;
    wait_done(1'b1, 10, k, d, other);
    lsb_req = 1'b0;
    check_eq("rdy_sb_done_edge", 32'(k + 3), 32'd3);
    tick();
    check_eq("rdy_sb_mem", 32'(mem[18'h00060]), 32'h77);
    check_eq("rdy_sb_count", 32'(wr_cnt - base), 32'd1);

    // Asynchronous reset mid-read discards the transfer
    if_req = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_mem_a", a, 32'h0);
    tick();
    if_req = 1'b0;
    rst_n = 1'b1;
    wait_done(1'b0, 10, k, d, other);
    check_eq("arst_no_done", 32'(k), 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
